// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the 9-bit CPU front end: instruction format,
// fetch FSM states and default geometry of the fetch stage.
package fetch_unit_pkg;

    localparam int unsigned INSTR_W        = 9;
    localparam int unsigned PC_W_DEF       = 10;
    localparam int unsigned START_ADDR_DEF = 0;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_LD  = 3'd4,
        OP_ST  = 3'd5,
        OP_JMP = 3'd6,
        OP_BRZ = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2,
        R3 = 2'd3
    } reg_t;

    // 9-bit instruction word as seen by the decoder
    typedef struct packed {
        opcode_t    op;
        reg_t       rd;
        reg_t       rs;
        logic [1:0] imm;
    } instr_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory and hands fetched words to the decoder with a valid flag.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W       = PC_W_DEF,
    parameter int unsigned START_ADDR = START_ADDR_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_W-1:0]     redirect_pc_i,
    input  logic                halt_i,
    output logic [PC_W-1:0]     imem_addr_o,
    output logic                imem_en_o,
    input  logic [INSTR_W-1:0]  imem_data_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [PC_W-1:0]     instr_pc_o,
    output logic                instr_valid_o,
    output logic                done,
    output logic [CNT_W-1:0]    retired_cnt_o
);

    localparam logic [1:0] ST_IDLE = FS_IDLE;
    localparam logic [1:0] ST_RUN  = FS_RUN;
    localparam logic [1:0] ST_HALT = FS_HALT;

    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state, state_n;
    logic [PC_W-1:0]  pc, pc_n;
    logic [PC_W-1:0]  instr_pc_n;
    logic             instr_valid_n;
    logic             done_n;
    logic [CNT_W-1:0] retired_cnt_n;
    logic             accept;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pc            <= START_PC;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
            done          <= 1'b0;
            retired_cnt_o <= '0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            instr_pc_o    <= instr_pc_n;
            instr_valid_o <= instr_valid_n;
            done          <= done_n;
            retired_cnt_o <= retired_cnt_n;
        end
    end

    // Decoder consumes the presented instruction this cycle
    assign accept = (state == ST_RUN) && instr_valid_o && !stall_i;

    // Next-state, next-PC mux and retirement bookkeeping
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_pc_n    = instr_pc_o;
        instr_valid_n = instr_valid_o;
        done_n        = done;
        retired_cnt_n = retired_cnt_o;

        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_n       = ST_RUN;
                    pc_n          = START_PC;
                    instr_valid_n = 1'b0;
                    done_n        = 1'b0;
                    retired_cnt_n = '0;
                end
            end
            ST_RUN: begin
                if (!stall_i) begin
                    if (accept && (retired_cnt_o != CNT_MAX)) begin
                        retired_cnt_n = retired_cnt_o + CNT_W'(1);
                    end
                    if (accept && halt_i) begin
                        state_n       = ST_HALT;
                        instr_valid_n = 1'b0;
                        done_n        = 1'b1;
                    end else if (accept && redirect_i) begin
                        // word already in flight from the old PC becomes a bubble
                        pc_n          = redirect_pc_i;
                        instr_valid_n = 1'b0;
                    end else begin
                        pc_n          = pc + PC_W'(1);
                        instr_pc_n    = pc;
                        instr_valid_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n       = ST_IDLE;
                instr_valid_n = 1'b0;
            end
        endcase
    end

    assign imem_addr_o = pc;
    assign imem_en_o   = (state == ST_RUN) && !stall_i;
    assign instr_o     = imem_data_i;

endmodule
